// File: rtl/mux_demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : mux_demux_pkg                                            |
// | Shared channel count, select width and round-robin reset pointer   |
// | for the 4-channel mux/demux stream family.                         |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
package mux_demux_pkg;

  localparam int N_CH  = 4;
  localparam int SEL_W = 2;

  typedef logic [SEL_W-1:0] sel_t;
  typedef logic [N_CH-1:0]  ch_mask_t;

  // Pointer value after reset: "last served" = 3, so channel 0 goes first.
  localparam sel_t RR_LAST_RST = 2'd3;

endpackage
`default_nettype wire

// File: rtl/mux4to1_rr_stream_rr_arbiter4.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : rr_arbiter4                                              |
// | Purely combinational 4-way round-robin arbiter. Search starts at   |
// | last+1 and wraps modulo 4; the first requester found wins.         |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module rr_arbiter4
  import mux_demux_pkg::*;
(
  input  logic [N_CH-1:0]  req,
  input  logic [SEL_W-1:0] last,
  output logic [N_CH-1:0]  gnt_onehot,
  output logic [SEL_W-1:0] gnt_idx,
  output logic             gnt_any
);

  sel_t w_cand;

  // Walk the priority order from lowest to highest so the highest-priority
  // requester (last+1) is the final assignment and therefore wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    w_cand  = '0;
    for (int k = N_CH; k >= 1; k--) begin
      w_cand = last + sel_t'(k);
      if (req[w_cand]) begin
        gnt_any = 1'b1;
        gnt_idx = w_cand;
      end
    end
  end

  // One-hot form of the winning index, all zero when nobody requests.
  always_comb begin
    gnt_onehot = '0;
    if (gnt_any) begin
      gnt_onehot = {{(N_CH-1){1'b0}}, 1'b1} << gnt_idx;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mux4to1_rr_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : mux4to1_rr_stream                                        |
// | Merges four valid/ready channels onto one registered output beat,  |
// | tagging each beat with its source channel. Round-robin fairness.   |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module mux4to1_rr_stream
  import mux_demux_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  En,
  input  logic [N_CH-1:0]       d_valid,
  output logic [N_CH-1:0]       d_ready,
  input  logic [N_CH*WIDTH-1:0] d,
  output logic                  y_valid,
  input  logic                  y_ready,
  output logic [WIDTH-1:0]      y,
  output logic [SEL_W-1:0]      y_sel
);

  logic [WIDTH-1:0] w_ch [N_CH];
  logic [N_CH-1:0]  w_gnt_onehot;
  sel_t             w_gnt_idx;
  logic             w_gnt_any;
  logic             w_free;
  logic             w_accept;

  sel_t             r_last;
  logic             r_y_valid;
  logic [WIDTH-1:0] r_y;
  sel_t             r_y_sel;

  // Split the flat data bus into per-channel words.
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_unpack
    assign w_ch[gi] = d[gi*WIDTH +: WIDTH];
  end

  rr_arbiter4 u_arb (
    .req        (d_valid),
    .last       (r_last),
    .gnt_onehot (w_gnt_onehot),
    .gnt_idx    (w_gnt_idx),
    .gnt_any    (w_gnt_any)
  );

  // Output slot can take a new beat when empty or draining this cycle;
  // y_ready reaches d_ready only through this term.
  assign w_free   = ~r_y_valid | y_ready;
  assign d_ready  = (En & w_free) ? w_gnt_onehot : '0;
  assign w_accept = |(d_valid & d_ready);

  // Output register and round-robin pointer; accept has priority over drain
  // so a drain-and-refill in one cycle keeps y_valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y_valid <= 1'b0;
      r_y       <= '0;
      r_y_sel   <= '0;
      r_last    <= RR_LAST_RST;
    end else if (w_accept) begin
      r_y_valid <= 1'b1;
      r_y       <= w_ch[w_gnt_idx];
      r_y_sel   <= w_gnt_idx;
      r_last    <= w_gnt_idx;
    end else if (r_y_valid && y_ready) begin
      r_y_valid <= 1'b0;
    end
  end

  assign y_valid = r_y_valid;
  assign y       = r_y;
  assign y_sel   = r_y_sel;

endmodule
`default_nettype wire

// File: tb/tb_mux4to1_rr_stream.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_mux4to1_rr_stream                                     |
// | Self-checking bench: vector table, directed corner sequences and   |
// | randomized traffic against a behavioural model.                    |
// | Revision: 1.0 - initial release                                    |
// +--------------------------------------------------------------------+
module tb_mux4to1_rr_stream;

  localparam int W = 8;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           En;
  logic [3:0]     d_valid;
  logic [3:0]     d_ready;
  logic [4*W-1:0] d;
  logic           y_valid;
  logic           y_ready;
  logic [W-1:0]   y;
  logic [1:0]     y_sel;

  int n_checks = 0;
  int n_pass   = 0;

  // Behavioural model state
  bit         m_valid;
  logic [7:0] m_y;
  int         m_sel;
  int         m_last;

  typedef struct {
    logic        en;
    logic [3:0]  dv;
    logic        yr;
    logic [31:0] dat;
    logic [3:0]  e_dready;
    logic        e_yvalid;
    logic [7:0]  e_y;
    logic [1:0]  e_sel;
  } vec_t;

  vec_t vecs [12];

  always #5 clk = ~clk;

  mux4to1_rr_stream #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .En      (En),
    .d_valid (d_valid),
    .d_ready (d_ready),
    .d       (d),
    .y_valid (y_valid),
    .y_ready (y_ready),
    .y       (y),
    .y_sel   (y_sel)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
  endtask

  // First channel with valid set, scanning (last+1)..(last+4) mod 4.
  function automatic int mgrant(input logic [3:0] v, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (v[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_y     = 8'h00;
    m_sel   = 0;
    m_last  = 3;
  endtask

  function automatic logic [3:0] model_ready();
    int g;
    g = mgrant(d_valid, m_last);
    if (En && (!m_valid || y_ready) && g >= 0) return 4'(1 << g);
    return 4'b0000;
  endfunction

  task automatic model_check(input string tag);
    chk({tag, ".d_ready"}, 32'(d_ready), 32'(model_ready()));
    chk({tag, ".y_valid"}, 32'(y_valid), 32'(m_valid));
    chk({tag, ".y"},       32'(y),       32'(m_y));
    chk({tag, ".y_sel"},   32'(y_sel),   32'(m_sel));
  endtask

  task automatic model_advance();
    int g;
    g = mgrant(d_valid, m_last);
    if (model_ready() != 4'b0000) begin
      m_valid = 1'b1;
      m_y     = d[g*W +: W];
      m_sel   = g;
      m_last  = g;
    end else if (m_valid && y_ready) begin
      m_valid = 1'b0;
    end
  endtask

  // One clock: settle, compare against the model, step the model, clock.
  task automatic cyc(input string tag);
    #1;
    model_check(tag);
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    // Expected outputs are what is seen during the row, before its edge.
    vecs[0]  = '{1'b1, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b0, 8'h00, 2'd0};
    vecs[1]  = '{1'b1, 4'b0100, 1'b1, 32'h00A5_0000, 4'b0100, 1'b0, 8'h00, 2'd0};
    vecs[2]  = '{1'b1, 4'b0000, 1'b1, 32'h0000_0000, 4'b0000, 1'b1, 8'hA5, 2'd2};
    vecs[3]  = '{1'b1, 4'b1111, 1'b1, 32'h1312_1110, 4'b1000, 1'b0, 8'hA5, 2'd2};
    vecs[4]  = '{1'b1, 4'b1111, 1'b1, 32'h1312_1110, 4'b0001, 1'b1, 8'h13, 2'd3};
    vecs[5]  = '{1'b1, 4'b1111, 1'b1, 32'h1312_1110, 4'b0010, 1'b1, 8'h10, 2'd0};
    vecs[6]  = '{1'b1, 4'b1111, 1'b0, 32'h1312_1110, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[7]  = '{1'b1, 4'b1111, 1'b0, 32'h1312_1110, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[8]  = '{1'b0, 4'b1111, 1'b1, 32'h1312_1110, 4'b0000, 1'b1, 8'h11, 2'd1};
    vecs[9]  = '{1'b0, 4'b1111, 1'b1, 32'h1312_1110, 4'b0000, 1'b0, 8'h11, 2'd1};
    vecs[10] = '{1'b1, 4'b1111, 1'b1, 32'h1312_1110, 4'b0100, 1'b0, 8'h11, 2'd1};
    vecs[11] = '{1'b1, 4'b0000, 1'b1, 32'h1312_1110, 4'b0000, 1'b1, 8'h12, 2'd2};

    rst_n   = 1'b0;
    En      = 1'b1;
    d_valid = 4'b0000;
    y_ready = 1'b1;
    d       = '0;
    model_reset();

    // Reset held for 3 cycles, outputs idle throughout
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst.y_valid", 32'(y_valid), 32'h0);
      chk("rst.y",       32'(y),       32'h0);
      chk("rst.y_sel",   32'(y_sel),   32'h0);
      chk("rst.d_ready", 32'(d_ready), 32'h0);
    end
    rst_n = 1'b1;

    // Vector table
    for (int i = 0; i < 12; i++) begin
      En      = vecs[i].en;
      d_valid = vecs[i].dv;
      y_ready = vecs[i].yr;
      d       = vecs[i].dat;
      #1;
      chk($sformatf("vec%0d.d_ready", i), 32'(d_ready), 32'(vecs[i].e_dready));
      chk($sformatf("vec%0d.y_valid", i), 32'(y_valid), 32'(vecs[i].e_yvalid));
      chk($sformatf("vec%0d.y", i),       32'(y),       32'(vecs[i].e_y));
      chk($sformatf("vec%0d.y_sel", i),   32'(y_sel),   32'(vecs[i].e_sel));
      @(posedge clk);
      #1;
    end

    // Back-pressure: hold a ch1 beat for 5 cycles, then drain-and-refill
    do_reset();
    En = 1'b1; y_ready = 1'b1; d_valid = 4'b0010; d = 32'h0000_3C00;
    cyc("bp.load");
    d_valid = 4'b1111; d = 32'h4433_2211; y_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp.hold.y",       32'(y),       32'h3C);
      chk("bp.hold.y_sel",   32'(y_sel),   32'h1);
      chk("bp.hold.d_ready", 32'(d_ready), 32'h0);
      cyc("bp.hold");
    end
    y_ready = 1'b1;
    #1;
    chk("bp.refill.d_ready", 32'(d_ready), 32'b0100);
    cyc("bp.refill");
    chk("bp.next.y",     32'(y),       32'h33);
    chk("bp.next.y_sel", 32'(y_sel),   32'h2);
    chk("bp.next.valid", 32'(y_valid), 32'h1);

    // Async reset between edges while a beat is held
    y_ready = 1'b0;
    #2;
    chk("ar.pre.y_valid", 32'(y_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("ar.y_valid", 32'(y_valid), 32'h0);
    chk("ar.y",       32'(y),       32'h0);
    chk("ar.y_sel",   32'(y_sel),   32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    y_ready = 1'b1; d_valid = 4'b1111;
    #1;
    chk("ar.first_grant", 32'(d_ready), 32'b0001);
    for (int i = 0; i < 5; i++) cyc("ar.rr");

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      En      = ($urandom_range(0, 7) != 0);
      d_valid = 4'($urandom);
      y_ready = ($urandom_range(0, 3) != 0);
      d       = $urandom;
      cyc("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
